// File: rtl/nv_nvdla_pdp_med2d_pkg.sv
// rtl/nv_nvdla_pdp_med2d_pkg.sv - shared geometry and state encoding for the PDP 2D median path
//
// Purpose: lane geometry, line-store depth and the row-pair/median FSM state
// encoding shared by the row-pair feeder and the median core.
package nv_nvdla_pdp_med2d_pkg;

  localparam int LANES      = 8;
  localparam int LANE_W     = 112;
  localparam int LINE_DEPTH = 64;
  localparam int AW         = $clog2(LINE_DEPTH);
  localparam int HW         = 13;                 // height counter width
  localparam int DW         = LANES * LANE_W;     // data bits per word
  localparam int SW         = DW + LANES;         // stored entry: {mask, data}

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PAIR  = 2'd2,
    DRAIN = 2'd3
  } med2d_state_e;

  // A lane of a row pair is usable only when both rows carried it.
  function automatic logic [LANES-1:0] pair_mask(input logic [LANES-1:0] upper,
                                                 input logic [LANES-1:0] lower);
    return upper & lower;
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_med2d_line_store.sv
// rtl/nv_nvdla_pdp_med2d_line_store.sv - one-line flop store holding the previous row
//
// Purpose: LINE_DEPTH x SW flop array with one synchronous write port and one
// asynchronous read port. A read and a write to the same address in the same
// cycle return the old contents (read-before-write). Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data {mask, data}
//   raddr  in   read address
//   rdata  out  read data (combinational)
module nv_nvdla_pdp_med2d_line_store
  import nv_nvdla_pdp_med2d_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [SW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [SW-1:0] rdata
);

  logic [SW-1:0] mem [LINE_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nv_nvdla_pdp_core_med2d_row_pair.sv
// rtl/nv_nvdla_pdp_core_med2d_row_pair.sv - row-pair feeder for the PDP 2D median core
//
// Purpose: accepts one surface as a raster of 8-lane words (one word per
// column), keeps the previous line in a line store and emits vertically
// aligned pairs (data0 = row r-1, data1 = row r) through a registered
// valid/ready stage.
// Ports:
//   nvdla_core_clk/rstn   clock, async active-low reset
//   op_en                 start pulse, latches cfg_*; ignored unless idle
//   cfg_line_words_m1     words per line minus 1
//   cfg_height_m1         lines per surface minus 1
//   in_pvld/in_prdy/in_pd/in_mask        input word stream
//   out_pvld/out_prdy/out_data0/out_data1/out_data0_valid
//   out_line_end/out_surf_end            output row-pair stream
//   done                  pulse when surface complete and output stage empty
//   busy                  not idle
module nv_nvdla_pdp_core_med2d_row_pair
  import nv_nvdla_pdp_med2d_pkg::*;
(
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             op_en,
  input  logic [AW-1:0]    cfg_line_words_m1,
  input  logic [HW-1:0]    cfg_height_m1,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [DW-1:0]    in_pd,
  input  logic [LANES-1:0] in_mask,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [DW-1:0]    out_data0,
  output logic [DW-1:0]    out_data1,
  output logic [LANES-1:0] out_data0_valid,
  output logic             out_line_end,
  output logic             out_surf_end,
  output logic             done,
  output logic             busy
);

  med2d_state_e state_q;
  logic [AW-1:0] col_q;
  logic [HW-1:0] row_q;
  logic [AW-1:0] cfg_lw_q;
  logic [HW-1:0] cfg_h_q;

  logic          in_acc;
  logic          line_end;
  logic          surf_end;
  logic [SW-1:0] rd_entry;

  // Input is only taken in FILL, and in PAIR when the output slot is free
  // or being emptied this cycle.
  always_comb begin
    in_prdy = 1'b0;
    case (state_q)
      FILL:    in_prdy = 1'b1;
      PAIR:    in_prdy = !out_pvld || out_prdy;
      default: in_prdy = 1'b0;
    endcase
  end

  assign in_acc   = in_pvld && in_prdy;
  assign line_end = (col_q == cfg_lw_q);
  assign surf_end = line_end && (row_q == cfg_h_q);
  assign busy     = (state_q != IDLE);

  // Same address for read and write: the store returns the previous row's
  // word while the current row's word overwrites it.
  nv_nvdla_pdp_med2d_line_store u_line_store (
    .clk   (nvdla_core_clk),
    .we    (in_acc),
    .waddr (col_q),
    .wdata ({in_mask, in_pd}),
    .raddr (col_q),
    .rdata (rd_entry)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      cfg_lw_q <= '0;
      cfg_h_q  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_en) begin
            cfg_lw_q <= cfg_line_words_m1;
            cfg_h_q  <= cfg_height_m1;
            col_q    <= '0;
            row_q    <= '0;
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (in_acc) begin
            if (line_end) begin
              col_q   <= '0;
              row_q   <= HW'(1);
              state_q <= (cfg_h_q != '0) ? PAIR : DRAIN;
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end
        PAIR: begin
          if (in_acc) begin
            if (line_end) begin
              col_q <= '0;
              if (row_q != '1) begin
                row_q <= row_q + HW'(1);
              end
              if (surf_end) begin
                state_q <= DRAIN;
              end
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          // Finish only once the last pair has left the output register.
          if (!out_pvld || out_prdy) begin
            done    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_pvld        <= 1'b0;
      out_data0       <= '0;
      out_data1       <= '0;
      out_data0_valid <= '0;
      out_line_end    <= 1'b0;
      out_surf_end    <= 1'b0;
    end else if ((state_q == PAIR) && in_acc) begin
      out_pvld        <= 1'b1;
      out_data0       <= rd_entry[DW-1:0];
      out_data1       <= in_pd;
      out_data0_valid <= pair_mask(rd_entry[DW +: LANES], in_mask);
      out_line_end    <= line_end;
      out_surf_end    <= surf_end;
    end else if (out_prdy) begin
      out_pvld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_core_med2d_row_pair.sv
// tb/tb_nv_nvdla_pdp_core_med2d_row_pair.sv - self-checking bench for the row-pair feeder
module tb_nv_nvdla_pdp_core_med2d_row_pair;

  localparam int LANES  = 8;
  localparam int LANE_W = 112;
  localparam int DW     = LANES * LANE_W;
  localparam int BUDGET = 4000;

  logic             clk;
  logic             rst_n;
  logic             op_en;
  logic [5:0]       cfg_line_words_m1;
  logic [12:0]      cfg_height_m1;
  logic             in_pvld;
  logic             in_prdy;
  logic [DW-1:0]    in_pd;
  logic [LANES-1:0] in_mask;
  logic             out_pvld;
  logic             out_prdy;
  logic [DW-1:0]    out_data0;
  logic [DW-1:0]    out_data1;
  logic [LANES-1:0] out_data0_valid;
  logic             out_line_end;
  logic             out_surf_end;
  logic             done;
  logic             busy;

  nv_nvdla_pdp_core_med2d_row_pair dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rst_n),
    .op_en             (op_en),
    .cfg_line_words_m1 (cfg_line_words_m1),
    .cfg_height_m1     (cfg_height_m1),
    .in_pvld           (in_pvld),
    .in_prdy           (in_prdy),
    .in_pd             (in_pd),
    .in_mask           (in_mask),
    .out_pvld          (out_pvld),
    .out_prdy          (out_prdy),
    .out_data0         (out_data0),
    .out_data1         (out_data1),
    .out_data0_valid   (out_data0_valid),
    .out_line_end      (out_line_end),
    .out_surf_end      (out_surf_end),
    .done              (done),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0]    d0;
    logic [DW-1:0]    d1;
    logic [LANES-1:0] v;
    logic             le;
    logic             se;
  } exp_t;

  exp_t             exp_q[$];
  logic [DW-1:0]    wd_q[$];
  logic [LANES-1:0] wm_q[$];

  int tests = 0;
  int fails = 0;
  int n_out, done_cnt, last_acc, last_out;
  bit abort;

  task automatic check(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [2047:0] out_snapshot();
    logic [2047:0] s;
    s = '0;
    s[1802:0] = {out_pvld, out_line_end, out_surf_end, out_data0_valid, out_data0, out_data1};
    return s;
  endfunction

  // Lane 0 carries row*16+col so pairs are easy to recognise; other lanes are random.
  function automatic logic [DW-1:0] make_word(input int r, input int c);
    logic [DW-1:0] w;
    logic [127:0]  t;
    w = '0;
    w[LANE_W-1:0] = LANE_W'(r * 16 + c);
    for (int b = 1; b < LANES; b++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      w[b*LANE_W +: LANE_W] = t[LANE_W-1:0];
    end
    return w;
  endfunction

  // pmode: 0 out_prdy=1, 1 out_prdy pattern 1,0,0, 2 random prdy and input gaps.
  // mmode: 0 mask FF, 1 row0 F0 / others 3C, 2 random.
  task automatic run_surface(input int w, input int h, input int pmode, input int mmode,
                             input int op_en_at, input int abort_at);
    int total;
    total = w * h;
    wd_q.delete();
    wm_q.delete();
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        wd_q.push_back(make_word(r, c));
        if (mmode == 0) wm_q.push_back(8'hFF);
        else if (mmode == 1) wm_q.push_back((r == 0) ? 8'hF0 : 8'h3C);
        else wm_q.push_back(8'($urandom()));
      end
    end
    // Reference: every word of row r>=1 pairs with the same column of row r-1.
    for (int r = 1; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_t e;
        e.d0 = wd_q[(r - 1) * w + c];
        e.d1 = wd_q[r * w + c];
        e.v  = wm_q[(r - 1) * w + c] & wm_q[r * w + c];
        e.le = (c == w - 1);
        e.se = e.le && (r == h - 1);
        exp_q.push_back(e);
      end
    end
    abort = 0; n_out = 0; done_cnt = 0; last_acc = 0; last_out = 0;

    @(posedge clk); #1;
    cfg_line_words_m1 = 6'(w - 1);
    cfg_height_m1     = 13'(h - 1);
    op_en = 1'b1;

    fork
      begin
        int  idx = 0;
        int  guard = 0;
        bit  op_sent = 0;
        while (idx < total && !abort && guard < BUDGET) begin
          @(posedge clk); #1;
          guard++;
          op_en = 1'b0;
          if (op_en_at >= 0 && idx == op_en_at && !op_sent) begin
            op_en = 1'b1;
            cfg_line_words_m1 = 6'd0;
            cfg_height_m1     = 13'd0;
            op_sent = 1;
          end
          in_pvld = (pmode == 2) ? ($urandom_range(3) != 0) : 1'b1;
          in_pd   = wd_q[idx];
          in_mask = wm_q[idx];
          @(negedge clk);
          if (in_pvld && in_prdy) begin
            last_acc = cyc;
            idx++;
          end
        end
        @(posedge clk); #1;
        in_pvld = 1'b0;
        op_en   = 1'b0;
      end
      begin
        int k = 0;
        int guard = 0;
        int post = 0;
        bit stalled = 0;
        logic [2047:0] snap;
        while (!abort && guard < BUDGET && !(done_cnt > 0 && post >= 3)) begin
          @(posedge clk); #1;
          case (pmode)
            0:       out_prdy = 1'b1;
            1:       out_prdy = (k % 3 == 0);
            default: out_prdy = 1'($urandom_range(1));
          endcase
          k++;
          @(negedge clk);
          guard++;
          if (done_cnt > 0) post++;
          if (stalled) check("stall_hold", out_snapshot(), snap);
          stalled = 0;
          if (done) begin
            done_cnt++;
            check("done_after_outputs", n_out, exp_q.size());
            if (exp_q.size() > 0) check("done_lat_out", cyc - last_out, 1);
            else check("done_lat_fill", cyc - last_acc, 2);
          end
          if (out_pvld && !out_prdy) begin
            check("in_prdy_stall", in_prdy, 0);
            stalled = 1;
            snap = out_snapshot();
          end
          if (out_pvld && out_prdy) begin
            check("output_in_range", n_out < exp_q.size(), 1);
            if (n_out < exp_q.size()) begin
              check("data0", out_data0, exp_q[n_out].d0);
              check("data1", out_data1, exp_q[n_out].d1);
              check("data0_valid", out_data0_valid, exp_q[n_out].v);
              check("line_end", out_line_end, exp_q[n_out].le);
              check("surf_end", out_surf_end, exp_q[n_out].se);
            end
            n_out++;
            last_out = cyc;
            if (n_out == abort_at) abort = 1;
          end
        end
        if (abort_at < 0) check("surface_timeout", guard < BUDGET, 1);
      end
    join
    in_pvld = 1'b0;
    op_en   = 1'b0;
    if (abort_at < 0) begin
      check("output_count", n_out, exp_q.size());
      check("done_once", done_cnt, 1);
      check("idle_after", busy, 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pvld"}, out_pvld, 0);
    check({tag, "_data0"}, out_data0, 0);
    check({tag, "_data1"}, out_data1, 0);
    check({tag, "_d0valid"}, out_data0_valid, 0);
    check({tag, "_flags"}, {out_line_end, out_surf_end, done, busy, in_prdy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op_en = 1'b0; cfg_line_words_m1 = '0; cfg_height_m1 = '0;
    in_pvld = 1'b0; in_pd = '0; in_mask = '0; out_prdy = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle_busy", busy, 0);

    // T1: 4 words x 3 lines, downstream always ready
    run_surface(4, 3, 0, 0, -1, -1);
    // T2: same geometry, downstream ready 1,0,0,...
    run_surface(4, 3, 1, 0, -1, -1);
    // T3: single-line surface, no pairs
    run_surface(6, 1, 0, 0, -1, -1);
    // T4: masks F0 then 3C
    run_surface(3, 3, 0, 1, -1, -1);
    // single-column lines
    run_surface(1, 4, 1, 0, -1, -1);

    // T5: reset after the third output, then a fresh surface
    run_surface(4, 3, 0, 0, -1, 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    @(negedge clk);
    check_cleared("held_reset");
    #2;
    rst_n = 1'b1;
    run_surface(4, 3, 0, 0, -1, -1);

    // T6: op_en during PAIR with a different cfg is ignored
    run_surface(4, 3, 1, 0, 6, -1);

    // randomized geometry, masks, stalls and input gaps
    for (int i = 0; i < 4; i++) begin
      run_surface($urandom_range(1, 8), $urandom_range(1, 4), 2, 2, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
